msf_encoder: RTL and testbench

MSF_ENCODER -- requirements
Module: msf_encoder

---
 rtl/msf_pkg.sv | 35 +++
 rtl/msf_encoder_if.sv | 23 ++
 rtl/msf_slot_timer.sv | 37 +++
 rtl/msf_encoder.sv | 113 +++++++++++
 tb/tb_msf_encoder.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msf_pkg.sv
// Shared MSF definitions used by the encoder and decoder-side blocks:
// FSM state encodings, slot indices within a second and the symbol layout.
package msf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MINUTE = 3'd1,
        ST_MARK   = 3'd2,
        ST_BIT_A  = 3'd3,
        ST_BIT_B  = 3'd4,
        ST_TAIL   = 3'd5
    } msf_state_t;

    localparam int SLOTS_PER_SECOND = 10;
    localparam int SLOT_W           = 4;

    localparam logic [SLOT_W-1:0] SLOT_MARK       = 4'd0;
    localparam logic [SLOT_W-1:0] SLOT_BIT_A      = 4'd1;
    localparam logic [SLOT_W-1:0] SLOT_BIT_B      = 4'd2;
    localparam logic [SLOT_W-1:0] SLOT_MINUTE_END = 4'd4;
    localparam logic [SLOT_W-1:0] SLOT_LAST       = 4'(SLOTS_PER_SECOND - 1);

    // One second's worth of information: minute marker flag or the A/B bits.
    typedef struct packed {
        logic is_00;
        logic bit_a;
        logic bit_b;
    } msf_symbol_t;

    // Slot index that follows the given one, wrapping after the last slot.
    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] slot);
        return (slot == SLOT_LAST) ? SLOT_MARK : slot + 4'd1;
    endfunction

endpackage

// File: rtl/msf_encoder_if.sv
// Symbol handshake between a time-code source and the MSF encoder.
interface msf_encoder_if;

    logic       bits_valid_i;
    logic       bits_is_second_00_i;
    logic [1:0] bits_data_i;
    logic       bits_ready_o;

    modport master (
        output bits_valid_i,
        output bits_is_second_00_i,
        output bits_data_i,
        input  bits_ready_o
    );

    modport slave (
        input  bits_valid_i,
        input  bits_is_second_00_i,
        input  bits_data_i,
        output bits_ready_o
    );

endinterface

// File: rtl/msf_slot_timer.sv
// Prescaler and slot counter for the MSF encoder. Both are held at zero while
// disabled so the first enabled cycle is always slot 0, prescaler 0.
module msf_slot_timer
    import msf_pkg::*;
#(
    parameter int CLKS_PER_SLOT = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable,
    output logic [SLOT_W-1:0] slot,
    output logic              slot_end,
    output logic              second_end
);

    localparam int PW = (CLKS_PER_SLOT > 1) ? $clog2(CLKS_PER_SLOT) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLKS_PER_SLOT - 1);

    logic [PW-1:0] prescaler;

    assign slot_end   = enable && (prescaler == PRESCALE_LAST);
    assign second_end = slot_end && (slot == SLOT_LAST);

    // Count clocks within a slot and slots within a second, both wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable) begin
            prescaler <= '0;
            slot      <= SLOT_MARK;
        end else if (prescaler == PRESCALE_LAST) begin
            prescaler <= '0;
            slot      <= next_slot(slot);
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

endmodule

// File: rtl/msf_encoder.sv
// MSF time-signal encoder: takes one symbol per second through a one-entry
// buffer and produces the carrier on/off pattern, ten slots per second.
module msf_encoder
    import msf_pkg::*;
#(
    parameter int CLKS_PER_SLOT = 1000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    msf_encoder_if.slave  bits,
    output logic          data_o,
    output logic          second_start_o,
    output logic          underrun_o
);

    msf_state_t        state;
    msf_symbol_t       buffer;
    msf_symbol_t       incoming;
    logic              buf_empty;
    logic              cur_a;
    logic              cur_b;
    logic              accept;
    logic              start_second;
    logic [SLOT_W-1:0] slot;
    logic              slot_end;
    logic              second_end;

    msf_slot_timer #(
        .CLKS_PER_SLOT(CLKS_PER_SLOT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .enable    (state != ST_IDLE),
        .slot      (slot),
        .slot_end  (slot_end),
        .second_end(second_end)
    );

    assign incoming.is_00    = bits.bits_is_second_00_i;
    assign incoming.bit_a    = bits.bits_data_i[1];
    assign incoming.bit_b    = bits.bits_data_i[0];
    assign bits.bits_ready_o = buf_empty;
    assign accept            = bits.bits_valid_i && buf_empty;
    // From idle a full buffer kicks off transmission; afterwards seconds
    // follow each other back to back on the timer's boundary strobe.
    assign start_second      = (state == ST_IDLE) ? !buf_empty : second_end;

    // One-entry symbol buffer: filled on a transfer, emptied when a second
    // starts. A transfer landing on the boundary edge waits for the next second.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_empty <= 1'b1;
            buffer    <= '0;
        end else if (accept) begin
            buf_empty <= 1'b0;
            buffer    <= incoming;
        end else if (start_second) begin
            buf_empty <= 1'b1;
        end
    end

    // Slot sequencer with registered carrier output and boundary pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            data_o         <= 1'b1;
            second_start_o <= 1'b0;
            underrun_o     <= 1'b0;
            cur_a          <= 1'b0;
            cur_b          <= 1'b0;
        end else begin
            second_start_o <= 1'b0;
            underrun_o     <= 1'b0;
            if (start_second) begin
                second_start_o <= 1'b1;
                underrun_o     <= buf_empty;
                data_o         <= 1'b0;
                if (!buf_empty && buffer.is_00) begin
                    state <= ST_MINUTE;
                end else begin
                    state <= ST_MARK;
                    cur_a <= buf_empty ? 1'b0 : buffer.bit_a;
                    cur_b <= buf_empty ? 1'b0 : buffer.bit_b;
                end
            end else if (slot_end) begin
                case (state)
                    ST_MINUTE: begin
                        if (slot == SLOT_MINUTE_END) begin
                            state  <= ST_TAIL;
                            data_o <= 1'b1;
                        end
                    end
                    ST_MARK: begin
                        state  <= ST_BIT_A;
                        data_o <= !cur_a;
                    end
                    ST_BIT_A: begin
                        state  <= ST_BIT_B;
                        data_o <= !cur_b;
                    end
                    ST_BIT_B: begin
                        state  <= ST_TAIL;
                        data_o <= 1'b1;
                    end
                    default: begin
                        data_o <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msf_encoder.sv
// Testbench for msf_encoder with CLKS_PER_SLOT=4 (40-cycle seconds).
// Outputs are compared every cycle against a second-level model that tracks
// the position inside the current second and the pending symbol.
module tb_msf_encoder;

    localparam int CPS = 4;
    localparam int SEC = 10 * CPS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic data_o;
    logic second_start_o;
    logic underrun_o;

    msf_encoder_if bits();

    msf_encoder #(
        .CLKS_PER_SLOT(CPS)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bits          (bits),
        .data_o        (data_o),
        .second_start_o(second_start_o),
        .underrun_o    (underrun_o)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    bit       m_running   = 1'b0;
    int       m_pos       = 0;
    bit [2:0] m_cur       = 3'b000;
    bit       m_ur_cur    = 1'b0;
    bit       m_pend_v    = 1'b0;
    bit [2:0] m_pend      = 3'b000;

    // Carrier level for a symbol {is_00, a, b} at a position within a second.
    function automatic logic wave(input bit [2:0] sym, input int pos);
        int s;
        s = pos / CPS;
        if (sym[2]) return (s >= 5);
        if (s == 0) return 1'b0;
        if (s == 1) return !sym[1];
        if (s == 2) return !sym[0];
        return 1'b1;
    endfunction

    // {ready, data, second_start, underrun} the model predicts for this cycle.
    function automatic logic [3:0] model_expected();
        if (!m_running) return {!m_pend_v, 1'b1, 1'b0, 1'b0};
        return {!m_pend_v, wave(m_cur, m_pos), m_pos == 0, (m_pos == 0) && m_ur_cur};
    endfunction

    function automatic logic [3:0] observed();
        return {bits.bits_ready_o, data_o, second_start_o, underrun_o};
    endfunction

    // Drive one cycle of inputs, step the model at the edge, return at negedge.
    task automatic applyStimulus(input logic v, input logic [2:0] sym, input logic r,
                                 output bit acc);
        rst                      = r;
        bits.bits_valid_i        = v;
        bits.bits_is_second_00_i = sym[2];
        bits.bits_data_i         = sym[1:0];
        acc = v && !m_pend_v && !r;
        @(posedge clk);
        if (r) begin
            m_running = 1'b0;
            m_pend_v  = 1'b0;
            m_pos     = 0;
        end else if (m_running && m_pos == SEC - 1) begin
            m_ur_cur = !m_pend_v;
            m_cur    = m_pend_v ? m_pend : 3'b000;
            m_pend_v = acc;
            if (acc) m_pend = sym;
            m_pos    = 0;
        end else if (m_running) begin
            m_pos = m_pos + 1;
            if (acc) begin
                m_pend_v = 1'b1;
                m_pend   = sym;
            end
        end else if (m_pend_v) begin
            m_running = 1'b1;
            m_pos     = 0;
            m_cur     = m_pend;
            m_ur_cur  = 1'b0;
            m_pend_v  = 1'b0;
        end else if (acc) begin
            m_pend_v = 1'b1;
            m_pend   = sym;
        end
        @(negedge clk);
    endtask

    function automatic logic [2:0] rand_sym();
        return {($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3))};
    endfunction

    task automatic test_reset();
        bit acc;
        logic [3:0] got;
        applyStimulus(1'b0, 3'b000, 1'b1, acc);
        applyStimulus(1'b0, 3'b000, 1'b1, acc);
        got = observed();
        tests_run++;
        if (got !== 4'b1100) begin
            tests_failed++;
            $display("[TB] FAIL reset_state got %b expected %b", got, 4'b1100);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 3'b000, 1'b0, acc);
            got = observed();
            tests_run++;
            if (got !== model_expected()) begin
                tests_failed++;
                $display("[TB] FAIL reset_idle cyc %0d got %b expected %b", i, got, model_expected());
            end
        end
    endtask

    task automatic test_single_symbol();
        bit acc;
        bit sent = 1'b0;
        int acc_cyc = -1;
        int ss_cyc = -1;
        int ur_count = 0;
        logic [3:0] got;
        applyStimulus(1'b0, 3'b000, 1'b1, acc);
        for (int i = 0; i < 80; i++) begin
            got = observed();
            tests_run++;
            if (got !== model_expected()) begin
                tests_failed++;
                $display("[TB] FAIL single_symbol cyc %0d got %b expected %b", i, got, model_expected());
            end
            if (got[1] && ss_cyc < 0) ss_cyc = i;
            if (got[0]) ur_count++;
            applyStimulus(!sent, 3'b010, 1'b0, acc);
            if (acc) begin
                sent = 1'b1;
                acc_cyc = i;
            end
        end
        tests_run++;
        if (acc_cyc < 0 || ss_cyc - acc_cyc != 2) begin
            tests_failed++;
            $display("[TB] FAIL single_latency got %0d expected 2", ss_cyc - acc_cyc);
        end
        tests_run++;
        if (ur_count != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_underrun got %0d expected 1", ur_count);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [2:0] q[$];
        int ur_count = 0;
        int ss_count = 0;
        logic [3:0] got;
        q.push_back(3'b001);
        q.push_back(3'b100);
        applyStimulus(1'b0, 3'b000, 1'b1, acc);
        for (int i = 0; i < 82; i++) begin
            got = observed();
            tests_run++;
            if (got !== model_expected()) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back cyc %0d got %b expected %b", i, got, model_expected());
            end
            if (got[1]) ss_count++;
            if (got[0]) ur_count++;
            applyStimulus(q.size() > 0, (q.size() > 0) ? q[0] : 3'b000, 1'b0, acc);
            if (acc) void'(q.pop_front());
        end
        tests_run++;
        if (ur_count != 0 || ss_count != 2) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_counts got ur=%0d ss=%0d expected ur=0 ss=2", ur_count, ss_count);
        end
    endtask

    task automatic test_boundary_offer();
        bit acc;
        bit sent1 = 1'b0;
        bit sent2 = 1'b0;
        bit v;
        logic [2:0] sym;
        int ur_count = 0;
        logic [3:0] got;
        applyStimulus(1'b0, 3'b000, 1'b1, acc);
        for (int i = 0; i < 120; i++) begin
            got = observed();
            tests_run++;
            if (got !== model_expected()) begin
                tests_failed++;
                $display("[TB] FAIL boundary_offer cyc %0d got %b expected %b", i, got, model_expected());
            end
            if (got[0]) ur_count++;
            v   = 1'b0;
            sym = rand_sym();
            if (!sent1) v = 1'b1;
            else if (!sent2 && m_running && m_pos == 0 && m_ur_cur) v = 1'b1;
            applyStimulus(v, sym, 1'b0, acc);
            if (acc && sent1) sent2 = 1'b1;
            if (acc) sent1 = 1'b1;
        end
        tests_run++;
        if (!sent2 || ur_count != 1) begin
            tests_failed++;
            $display("[TB] FAIL boundary_counts got sent=%0d ur=%0d expected sent=1 ur=1", sent2, ur_count);
        end
    endtask

    task automatic test_reset_mid_marker();
        bit acc;
        bit sent = 1'b0;
        bit did_reset = 1'b0;
        bit r;
        int ss_after = 0;
        logic [3:0] got;
        applyStimulus(1'b0, 3'b000, 1'b1, acc);
        for (int i = 0; i < 100; i++) begin
            got = observed();
            tests_run++;
            if (got !== model_expected()) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid cyc %0d got %b expected %b", i, got, model_expected());
            end
            if (did_reset && got[1]) ss_after++;
            r = !did_reset && m_running && m_pos == 6;
            applyStimulus(!sent, 3'b100, r, acc);
            if (acc) sent = 1'b1;
            if (r) begin
                did_reset = 1'b1;
                got = observed();
                tests_run++;
                if (got !== 4'b1100) begin
                    tests_failed++;
                    $display("[TB] FAIL reset_mid_after got %b expected %b", got, 4'b1100);
                end
            end
        end
        tests_run++;
        if (!did_reset || ss_after != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_quiet got ss=%0d expected 0", ss_after);
        end
        for (int i = 0; i < 50; i++) begin
            applyStimulus(i == 0, 3'b011, 1'b0, acc);
            got = observed();
            tests_run++;
            if (got !== model_expected()) begin
                tests_failed++;
                $display("[TB] FAIL reset_restart cyc %0d got %b expected %b", i, got, model_expected());
            end
        end
    endtask

    task automatic test_random_stream();
        bit acc;
        logic [2:0] sym;
        int accepts = 0;
        int ss_count = 0;
        int ur_count = 0;
        logic [3:0] got;
        applyStimulus(1'b0, 3'b000, 1'b1, acc);
        sym = rand_sym();
        for (int i = 0; i < 8 * SEC; i++) begin
            got = observed();
            tests_run++;
            if (got !== model_expected()) begin
                tests_failed++;
                $display("[TB] FAIL stream_held cyc %0d got %b expected %b", i, got, model_expected());
            end
            if (got[1]) ss_count++;
            if (got[0]) ur_count++;
            applyStimulus(1'b1, sym, 1'b0, acc);
            if (acc) begin
                accepts++;
                sym = rand_sym();
            end
        end
        tests_run++;
        if (accepts != ss_count + 1 || ur_count != 0) begin
            tests_failed++;
            $display("[TB] FAIL stream_counts got acc=%0d ss=%0d ur=%0d expected acc=ss+1 ur=0",
                     accepts, ss_count, ur_count);
        end
        for (int i = 0; i < 8 * SEC; i++) begin
            applyStimulus($urandom_range(0, 99) < 3, rand_sym(), 1'b0, acc);
            got = observed();
            tests_run++;
            if (got !== model_expected()) begin
                tests_failed++;
                $display("[TB] FAIL stream_random cyc %0d got %b expected %b", i, got, model_expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_symbol();
        test_back_to_back();
        test_boundary_offer();
        test_reset_mid_marker();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
